out_port_arbiter: RTL and testbench

OUT_PORT_ARBITER -- requirements
Module: out_port_arbiter

---
 rtl/out_port_arbiter.sv | 97 +++++++++
 tb/tb_out_port_arbiter.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/out_port_arbiter.sv
// Per-output switch arbiter with a packet lock. Head flits are arbitrated
// round-robin, and the winner keeps the output until its tail flit is sent.
module out_port_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] req_i,
  input  logic [4:0] head_i,
  input  logic [4:0] tail_i,
  input  logic       credit_en_i,
  output logic [4:0] gnt_o,
  output logic       valid_o,
  output logic       decr_o,
  output logic       busy_o
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t     state, state_nxt;
  logic [2:0] ptr, ptr_nxt;
  logic [2:0] owner, owner_nxt;
  logic [4:0] eligible;
  logic [3:0] sum;
  logic [2:0] idx;
  logic [2:0] win;
  logic       found;

  function automatic logic [2:0] inc_mod5(input logic [2:0] v);
    return (v == 3'd4) ? 3'd0 : v + 3'd1;
  endfunction

  assign eligible = req_i & head_i;

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    gnt_o     = '0;
    state_nxt = state;
    ptr_nxt   = ptr;
    owner_nxt = owner;
    found     = 1'b0;
    win       = ptr;
    sum       = '0;
    idx       = '0;
    // Reset and missing credit both suppress any grant and freeze the state.
    if (!rst && credit_en_i) begin
      case (state)
        IDLE: begin
          for (int k = 0; k < 5; k++) begin
            sum = {1'b0, ptr} + 4'(k);
            idx = (sum >= 4'd5) ? 3'(sum - 4'd5) : sum[2:0];
            if (!found && eligible[idx]) begin
              found = 1'b1;
              win   = idx;
            end
          end
          if (found) begin
            gnt_o[win] = 1'b1;
            if (tail_i[win]) begin
              ptr_nxt = inc_mod5(win);
            end else begin
              state_nxt = LOCKED;
              owner_nxt = win;
            end
          end
        end
        LOCKED: begin
          // Only the owner is served; a stray head flit is forwarded as body.
          if (req_i[owner]) begin
            gnt_o[owner] = 1'b1;
            if (tail_i[owner]) begin
              state_nxt = IDLE;
              ptr_nxt   = inc_mod5(owner);
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign valid_o = |gnt_o;
  assign decr_o  = valid_o;
  assign busy_o  = (state == LOCKED) && !rst;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      state <= IDLE;
      ptr   <= '0;
      owner <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      owner <= owner_nxt;
    end
  end

endmodule

// File: tb/tb_out_port_arbiter.sv
// Self-checking bench for out_port_arbiter: directed scenarios with literal
// expectations, then randomized traffic checked against a packet-level model.
module tb_out_port_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] req_i, head_i, tail_i;
  logic       credit_en_i;
  logic [4:0] gnt_o;
  logic       valid_o, decr_o, busy_o;

  int checks   = 0;
  int failures = 0;

  // Reference model: packet lock flag, round-robin start index, lock owner.
  bit m_locked = 1'b0;
  int m_ptr    = 0;
  int m_owner  = 0;

  out_port_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .req_i       (req_i),
    .head_i      (head_i),
    .tail_i      (tail_i),
    .credit_en_i (credit_en_i),
    .gnt_o       (gnt_o),
    .valid_o     (valid_o),
    .decr_o      (decr_o),
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Index of the input that must be served this cycle, or -1 for none.
  function automatic int model_winner();
    if (rst || !credit_en_i) return -1;
    if (m_locked) return req_i[m_owner] ? m_owner : -1;
    for (int k = 0; k < 5; k++) begin
      int i = (m_ptr + k) % 5;
      if (req_i[i] && head_i[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [4:0] model_gnt();
    int w = model_winner();
    return (w < 0) ? 5'b0 : 5'(1 << w);
  endfunction

  always @(negedge clk) begin
    logic [4:0] g;
    g = model_gnt();
    check("model_gnt",   {27'b0, gnt_o}, {27'b0, g});
    check("model_valid", {31'b0, valid_o}, {31'b0, |g});
    check("model_decr",  {31'b0, decr_o}, {31'b0, |g});
    check("model_busy",  {31'b0, busy_o}, {31'b0, m_locked && !rst});
  end

  always @(posedge clk) begin
    int w;
    w = model_winner();
    if (rst) begin
      m_locked = 1'b0;
      m_ptr    = 0;
      m_owner  = 0;
    end else if (w >= 0) begin
      if (tail_i[w]) begin
        m_locked = 1'b0;
        m_ptr    = (w + 1) % 5;
      end else if (!m_locked) begin
        m_locked = 1'b1;
        m_owner  = w;
      end
    end
  end

  task automatic drive(input logic r, input logic [4:0] rq, input logic [4:0] hd,
                       input logic [4:0] tl, input logic cr);
    @(posedge clk);
    #1;
    rst = r; req_i = rq; head_i = hd; tail_i = tl; credit_en_i = cr;
  endtask

  task automatic expect_now(input string name, input logic [4:0] g, input logic b);
    @(negedge clk);
    check({name, "_gnt"},  {27'b0, gnt_o}, {27'b0, g});
    check({name, "_decr"}, {31'b0, decr_o}, {31'b0, |g});
    check({name, "_busy"}, {31'b0, busy_o}, {31'b0, b});
  endtask

  initial begin
    logic [4:0] rot [6];
    rot = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00001};
    rst = 1'b1; req_i = '0; head_i = '0; tail_i = '0; credit_en_i = 1'b0;
    drive(1'b1, 5'b11111, 5'b11111, 5'b11111, 1'b1);
    expect_now("reset", 5'b00000, 1'b0);

    // Two heads contend from ptr=0; input 0 wins and locks.
    drive(1'b0, 5'b10001, 5'b10001, 5'b00000, 1'b1);
    expect_now("first_grant", 5'b00001, 1'b0);
    drive(1'b0, 5'b10001, 5'b10000, 5'b00000, 1'b1);
    expect_now("locked_body1", 5'b00001, 1'b1);
    drive(1'b0, 5'b10001, 5'b10000, 5'b00000, 1'b1);
    expect_now("locked_body2", 5'b00001, 1'b1);
    drive(1'b0, 5'b10001, 5'b10000, 5'b00001, 1'b1);
    expect_now("locked_tail", 5'b00001, 1'b1);
    // ptr=1 now, so input 4 beats input 0.
    drive(1'b0, 5'b10001, 5'b10001, 5'b10001, 1'b1);
    expect_now("after_tail", 5'b10000, 1'b0);

    // Single-flit packets everywhere rotate from ptr=0.
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 5'b11111, 5'b11111, 5'b11111, 1'b1);
      expect_now("rotate", rot[i], 1'b0);
    end

    // ptr=1: lock on input 2, then starve credit.
    drive(1'b0, 5'b00100, 5'b00100, 5'b00000, 1'b1);
    expect_now("lock2", 5'b00100, 1'b0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 5'b11111, 5'b11111, 5'b00000, 1'b0);
      expect_now("no_credit", 5'b00000, 1'b1);
    end
    drive(1'b0, 5'b11111, 5'b11111, 5'b00000, 1'b1);
    expect_now("credit_back", 5'b00100, 1'b1);
    drive(1'b0, 5'b00100, 5'b00000, 5'b00100, 1'b1);
    expect_now("tail2", 5'b00100, 1'b1);

    // Requests without a head flit are never served in IDLE.
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 5'b00010, 5'b00000, 5'b00010, 1'b1);
      expect_now("no_head", 5'b00000, 1'b0);
    end

    // ptr=3: lock on input 3, then reset mid-packet.
    drive(1'b0, 5'b01000, 5'b01000, 5'b00000, 1'b1);
    expect_now("lock3", 5'b01000, 1'b0);
    drive(1'b0, 5'b00000, 5'b00000, 5'b00000, 1'b1);
    expect_now("lock3_idle", 5'b00000, 1'b1);
    drive(1'b1, 5'b01000, 5'b00000, 5'b00000, 1'b1);
    expect_now("mid_reset", 5'b00000, 1'b0);
    drive(1'b0, 5'b01001, 5'b01001, 5'b01001, 1'b1);
    expect_now("post_reset", 5'b00001, 1'b0);

    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 49) == 0), 5'($urandom), 5'($urandom), 5'($urandom),
            ($urandom_range(0, 3) != 0));
    end

    @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
